// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter that serialises whole SCCB write transactions from two requesters onto one engine.
// Define SCCB_RETRY_EN to re-issue NACKed frames up to MAX_RETRY times before reporting an error.
module sccb_cmd_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clock_i2c,
    input  logic        camera_rst,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        gnt0,
    output logic        done0,
    output logic        err0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt1,
    output logic        done1,
    output logic        err1,
    output logic [31:0] i2c_data,
    output logic        start,
    input  logic        tr_end,
    input  logic        ack,
    output logic        busy
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RECOVER,
        S_COMPLETE
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic            r_nack;
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_gnt;
    logic [1:0]      r_done;
    logic [1:0]      r_err;
    logic [31:0]     r_i2c_data;
    logic            r_start;
    logic            r_busy;

`ifdef SCCB_RETRY_EN
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RT_W-1:0] r_retry_cnt;
`endif

    // With both requests pending the side that did not win last time goes next.
    logic w_any;
    logic w_pick;
    assign w_any  = req0 | req1;
    assign w_pick = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clock_i2c) begin
        if (camera_rst) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_nack     <= 1'b0;
            r_to_cnt   <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_i2c_data <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SCCB_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking default-then-override keeps done/err as one-cycle pulses; a later <= in the case wins.
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_i2c_data <= w_pick ? data1 : data0;
                        r_gnt      <= w_pick ? 2'b10 : 2'b01;
                        r_last     <= w_pick;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_nack     <= 1'b0;
                        r_to_cnt   <= '0;
`ifdef SCCB_RETRY_EN
                        r_retry_cnt <= '0;
`endif
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (tr_end) begin
                        r_start <= 1'b0;
                        r_nack  <= ack;
                        r_state <= S_RECOVER;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_start        <= 1'b0;
                        r_done[r_last] <= 1'b1;
                        r_err[r_last]  <= 1'b1;
                        r_state        <= S_COMPLETE;
                    end
                end
                S_RECOVER: begin
                    // Wait for the engine to close its handshake before reusing it.
                    if (!tr_end) begin
`ifdef SCCB_RETRY_EN
                        if (r_nack && (r_retry_cnt < RT_W'(MAX_RETRY))) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_to_cnt    <= '0;
                            r_start     <= 1'b1;
                            r_state     <= S_XFER;
                        end else
`endif
                        begin
                            r_done[r_last] <= 1'b1;
                            r_err[r_last]  <= r_nack;
                            r_state        <= S_COMPLETE;
                        end
                    end
                end
                S_COMPLETE: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt0     = r_gnt[0];
    assign gnt1     = r_gnt[1];
    assign done0    = r_done[0];
    assign done1    = r_done[1];
    assign err0     = r_err[0];
    assign err1     = r_err[1];
    assign i2c_data = r_i2c_data;
    assign start    = r_start;
    assign busy     = r_busy;

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Randomised self-checking bench for sccb_cmd_arbiter with a transaction-level round-robin model.
// Honours SCCB_RETRY_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_sccb_cmd_arbiter;
    localparam int TIMEOUT_CYC = 255;
    localparam int MAX_RETRY   = 3;
`ifdef SCCB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        camera_rst = 1'b1;
    logic [1:0]  req = '0;
    logic [31:0] data [2];
    logic        tr_end = 1'b0;
    logic        ack = 1'b0;
    wire  [1:0]  gnt;
    wire  [1:0]  done;
    wire  [1:0]  err;
    wire  [31:0] i2c_data;
    wire         start;
    wire         busy;

    always #5 clk = ~clk;

    sccb_cmd_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clock_i2c (clk),
        .camera_rst(camera_rst),
        .req0      (req[0]),
        .data0     (data[0]),
        .gnt0      (gnt[0]),
        .done0     (done[0]),
        .err0      (err[0]),
        .req1      (req[1]),
        .data1     (data[1]),
        .gnt1      (gnt[1]),
        .done1     (done[1]),
        .err1      (err[1]),
        .i2c_data  (i2c_data),
        .start     (start),
        .tr_end    (tr_end),
        .ack       (ack),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Engine model: raises tr_end eng_delay cycles into a transfer, holds it until start drops.
    bit eng_hang = 1'b0;
    bit eng_rand = 1'b0;
    int eng_delay = 4;
    int eng_cnt = 0;
    bit ack_q [$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (camera_rst) begin
                tr_end  = 1'b0;
                ack     = 1'b0;
                eng_cnt = 0;
            end else if (tr_end) begin
                if (!start) begin
                    tr_end  = 1'b0;
                    ack     = 1'b0;
                    eng_cnt = 0;
                    if (eng_rand) eng_delay = $urandom_range(1, 20);
                end
            end else if (start) begin
                eng_cnt++;
                if (!eng_hang && eng_cnt >= eng_delay) begin
                    tr_end = 1'b1;
                    ack    = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                end
            end
        end
    end

    // Monitor: protocol invariants plus a log of grants and completions.
    int          viol = 0;
    int          start_cnt = 0;
    bit          obs_gid [$];
    logic [31:0] obs_data [$];
    bit          obs_did [$];
    bit          obs_err [$];
    logic [1:0]  p_gnt = '0;
    logic [1:0]  p_done = '0;
    logic        p_start = 1'b0;
    logic [31:0] p_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (gnt == 2'b11) viol++;
            if (start && !(busy && (gnt[0] ^ gnt[1]))) viol++;
            if ((done & ~gnt) != 2'b00) viol++;
            if ((done & p_done) != 2'b00) viol++;
            if ((err & ~done) != 2'b00) viol++;
            if (((gnt & p_gnt) != 2'b00) && (i2c_data != p_data)) viol++;
            if (start && !p_start) start_cnt++;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i] && !p_gnt[i]) begin
                    obs_gid.push_back(i[0]);
                    obs_data.push_back(i2c_data);
                end
                if (done[i]) begin
                    obs_did.push_back(i[0]);
                    obs_err.push_back(err[i]);
                end
            end
            p_gnt   = gnt;
            p_done  = done;
            p_start = start;
            p_data  = i2c_data;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    bit m_last = 1'b1;

    task automatic apply_reset();
        @(negedge clk);
        camera_rst = 1'b1;
        req        = '0;
        repeat (2) @(negedge clk);
        camera_rst = 1'b0;
        m_last     = 1'b1;
    endtask

    task automatic wait_done(input int id, input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done[id] && k < budget);
        if (!done[id]) check({tag, "_wait_done"}, 32'd0, 32'd1);
    endtask

    task automatic drive_req(input int id, input logic [31:0] list [$]);
        foreach (list[k]) begin
            data[id] = list[k];
            req[id]  = 1'b1;
            wait_done(id, 3000, "pair");
        end
        req[id] = 1'b0;
    endtask

    // Model: both requesters keep requests pending, so grants alternate from the side that did not win last.
    task automatic run_pair(input int n0, input int n1, input string tag);
        logic [31:0] l0 [$];
        logic [31:0] l1 [$];
        bit          e_id [$];
        logic [31:0] e_data [$];
        bit          e_err [$];
        int          i0 = 0;
        int          i1 = 0;
        int          att_total = 0;
        int          att;
        int          s0;
        int          nmin;
        bit          turn;
        bit          pick;
        bit          a;
        for (int k = 0; k < n0; k++) l0.push_back($urandom);
        for (int k = 0; k < n1; k++) l1.push_back($urandom);
        ack_q.delete();
        turn = ~m_last;
        while (i0 < n0 || i1 < n1) begin
            if (i0 >= n0) pick = 1'b1;
            else if (i1 >= n1) pick = 1'b0;
            else pick = turn;
            e_id.push_back(pick);
            if (pick) begin
                e_data.push_back(l1[i1]);
                i1++;
            end else begin
                e_data.push_back(l0[i0]);
                i0++;
            end
            att = 0;
            do begin
                a = 1'($urandom_range(0, 1));
                ack_q.push_back(a);
                att++;
            end while (RETRY_EN && a && att < MAX_RETRY + 1);
            e_err.push_back(a);
            att_total += att;
            turn   = ~pick;
            m_last = pick;
        end
        eng_rand  = 1'b1;
        eng_delay = $urandom_range(1, 20);
        @(negedge clk);
        #1;
        obs_gid.delete();
        obs_data.delete();
        obs_did.delete();
        obs_err.delete();
        s0 = start_cnt;
        fork
            drive_req(0, l0);
            drive_req(1, l1);
        join
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_n_grants"}, obs_gid.size(), e_id.size());
        check({tag, "_n_done"}, obs_did.size(), e_id.size());
        check({tag, "_starts"}, start_cnt - s0, att_total);
        nmin = (obs_did.size() < e_id.size()) ? obs_did.size() : e_id.size();
        if (obs_gid.size() < nmin) nmin = obs_gid.size();
        for (int k = 0; k < nmin; k++) begin
            check($sformatf("%s_gnt_id[%0d]", tag, k), obs_gid[k], e_id[k]);
            check($sformatf("%s_data[%0d]", tag, k), obs_data[k], e_data[k]);
            check($sformatf("%s_done_id[%0d]", tag, k), obs_did[k], e_id[k]);
            check($sformatf("%s_err[%0d]", tag, k), obs_err[k], e_err[k]);
        end
    endtask

    task automatic nack_test(input bit acks [$], input int exp_starts, input bit exp_err, input string tag);
        int s0;
        eng_rand  = 1'b0;
        eng_delay = 5;
        ack_q     = acks;
        @(negedge clk);
        #1;
        s0      = start_cnt;
        data[0] = $urandom;
        req[0]  = 1'b1;
        wait_done(0, 500, tag);
        check({tag, "_err0"}, err[0], exp_err);
        req[0] = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_starts"}, start_cnt - s0, exp_starts);
    endtask

    initial begin
        int s0;
        int n;
        int n_done;
        data[0] = '0;
        data[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_start", start, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_i2c_data", i2c_data, 0);
        camera_rst = 1'b0;

        // Single request with a 40-cycle engine
        eng_rand  = 1'b0;
        eng_delay = 40;
        @(negedge clk);
        #1;
        s0      = start_cnt;
        data[0] = 32'h78310311;
        req[0]  = 1'b1;
        check("t1_start_pre", start, 0);
        @(negedge clk);
        check("t1_start", start, 1);
        check("t1_gnt0", gnt, 2'b01);
        check("t1_data", i2c_data, 32'h78310311);
        check("t1_busy", busy, 1);
        wait_done(0, 200, "t1");
        check("t1_err0", err[0], 0);
        check("t1_start_low", start, 0);
        check("t1_gnt_during_done", gnt[0], 1);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_done_cleared", done[0], 0);
        check("t1_gnt_released", gnt[0], 0);
        check("t1_busy_idle", busy, 0);
        #1;
        check("t1_starts", start_cnt - s0, 1);

        // Simultaneous requests, three each, from reset
        apply_reset();
        run_pair(3, 3, "rr33");

        // Randomised pairs, round-robin state carried across runs
        for (int r = 0; r < 6; r++) begin
            run_pair($urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rnd%0d", r));
        end

        // NACK handling
        if (RETRY_EN) begin
            nack_test('{1'b1, 1'b1, 1'b1, 1'b1}, MAX_RETRY + 1, 1'b1, "nack_all");
            nack_test('{1'b1, 1'b0}, 2, 1'b0, "nack_once");
        end else begin
            nack_test('{1'b1}, 1, 1'b1, "nack");
            nack_test('{1'b0}, 1, 1'b0, "ack_ok");
        end

        // Timeout: engine never answers
        eng_hang = 1'b1;
        ack_q.delete();
        @(negedge clk);
        data[1] = $urandom;
        req[1]  = 1'b1;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (start) n++;
            else if (n > 0) break;
        end
        check("to_xfer_cycles", n, TIMEOUT_CYC);
        check("to_done1", done[1], 1);
        check("to_err1", err[1], 1);
        req[1] = 1'b0;
        @(negedge clk);
        check("to_busy_after", busy, 0);
        check("to_gnt1_after", gnt[1], 0);
        check("to_done1_after", done[1], 0);
        eng_hang = 1'b0;

        // Reset at cycle 10 of a transfer, then re-grant
        eng_rand  = 1'b0;
        eng_delay = 40;
        ack_q.delete();
        @(negedge clk);
        data[0] = 32'hA5A51234;
        req[0]  = 1'b1;
        @(negedge clk);
        check("rm_start", start, 1);
        repeat (9) @(negedge clk);
        #1;
        n_done     = obs_did.size();
        camera_rst = 1'b1;
        @(negedge clk);
        check("rm_start_drop", start, 0);
        check("rm_gnt0_drop", gnt[0], 0);
        check("rm_busy_drop", busy, 0);
        check("rm_no_done", done, 0);
        camera_rst = 1'b0;
        @(negedge clk);
        check("rm_regrant_start", start, 1);
        check("rm_regrant_gnt", gnt, 2'b01);
        check("rm_regrant_data", i2c_data, 32'hA5A51234);
        #1;
        check("rm_no_done_logged", obs_did.size(), n_done);
        wait_done(0, 200, "rm");
        check("rm_err0", err[0], 0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        check("invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sccb_cmd_arbiter.md
Name: sccb_cmd_arbiter

Overview:
- Shares one SCCB/I2C write engine (32-bit frame {dev_addr, reg_addr[15:0], data[7:0]}, start/tr_end handshake) between two register-write requesters.
- Typical requesters: the boot-time OV5640 init sequencer and a runtime tuning sequencer (exposure/AWB), or the init sequencers of two cameras.
- Runs in the I2C clock domain and serializes whole transactions with round-robin arbitration.
- Reports per-requester completion and error (NACK or timeout).

Parameters:
- TIMEOUT_CYC, 255: max clock_i2c cycles in XFER waiting for tr_end before abort.
- MAX_RETRY, 3: NACK retries per transaction; used only with SCCB_RETRY_EN.

Ports:
- clock_i2c  in  1  I2C sequencing clock (20 kHz).
- camera_rst  in  1  synchronous reset, active-high.
- req0  in  1  requester 0 request; level, held until done0.
- data0  in  32  requester 0 frame; stable while req0 is high.
- gnt0  out  1  requester 0 owns the engine.
- done0  out  1  one-cycle completion pulse.
- err0  out  1  valid with done0; 1 = NACK or timeout.
- req1/data1/gnt1/done1/err1: same as requester 0.
- i2c_data  out  32  frame to the engine.
- start  out  1  engine start; held high until tr_end.
- tr_end  in  1  engine transfer-end.
- ack  in  1  engine ack status, sampled at tr_end; 1 = NACK.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (camera_rst high at a clock edge): state=IDLE, start=0, i2c_data=0, gnt0/1=0, done0/1=0, err0/1=0, busy=0, last=1 (so requester 0 wins first), to_cnt=0, retry_cnt=0. Reset mid-transaction drops start on that edge with no done pulse. Requesters re-request after reset.
- IDLE:
  - If only reqX is high, X wins.
  - If both are high, the requester != last wins.
  - On the winning edge: latch dataX into i2c_data, set gntX=1, start=1, to_cnt=0, retry_cnt=0, last=X, go to XFER.
  - start is visible 1 cycle after req is sampled.
- XFER:
  - to_cnt increments each cycle.
  - On tr_end=1: start=0, capture nack=ack, go to RECOVER.
  - Else if to_cnt==TIMEOUT_CYC-1: start=0, err=1, go to COMPLETE. RECOVER is skipped.
  - tr_end takes priority over a timeout in the same cycle.
- RECOVER: wait for tr_end=0 (engine handshake closed), then go to COMPLETE. Retry path: see Optional Feature.
- COMPLETE (one cycle):
  - doneX=1, errX=nack|timeout, gntX=0.
  - Go to IDLE; the next arbitration happens in IDLE on the following edge.
  - done and err are single-cycle pulses and return to 0 next cycle.
- gntX is high from the edge leaving IDLE through the COMPLETE cycle.
- i2c_data is constant while gntX is high; data changes on reqX are ignored after latch.
- reqX dropped while granted: the transaction still completes and doneX still pulses.
- reqX still high after doneX is treated as a new request; round-robin still applies.
- At most one grant is high at any time. start is never high outside XFER.
- Counters: to_cnt width is clog2(TIMEOUT_CYC+1) and saturates. retry_cnt width is clog2(MAX_RETRY+1).

Optional Feature:
- Macro: SCCB_RETRY_EN.
- Defined: in RECOVER, if nack=1 and retry_cnt<MAX_RETRY, then after tr_end=0:
  - retry_cnt++, to_cnt=0, start=1, return to XFER with the same i2c_data.
  - No done pulse between attempts; gnt stays high.
  - After MAX_RETRY failed retries, COMPLETE with err=1. Timeouts are never retried.
- Undefined: no retry logic; a NACK goes straight to COMPLETE with err=1.

Test Plan:
- Single request: req0=1, data0=32'h78310311, engine model gives tr_end at 40 cycles with ack=0.
  - Expect start 1 cycle after req, i2c_data=32'h78310311, start low after tr_end, done0 pulse with err0=0.
- Simultaneous requests: req0 and req1 raised on the same edge, both held for 3 transactions each.
  - Expect grants in order 0,1,0,1,0,1; never both gnt high.
- NACK without the macro: engine returns ack=1.
  - Expect done0 with err0=1 and exactly one start assertion.
  - With SCCB_RETRY_EN and MAX_RETRY=3, ack always 1: expect 4 start assertions, then done0 with err0=1.
  - With SCCB_RETRY_EN, ack=1 then 0: expect 2 starts, err0=0.
- Timeout: TIMEOUT_CYC=255, tr_end never asserted.
  - Expect start to drop after 255 XFER cycles, done1 with err1=1, busy=0 next cycle.
- Reset mid-XFER: assert camera_rst at cycle 10 of a transfer.
  - Expect start=0, gnt0=0, busy=0 on that edge, no done pulse. After release, a pending req0 is re-granted normally.
